bcd_serial_addsub: RTL and testbench

//   Parametrised multi-digit packed-BCD adder/subtractor, digit-serial: one decimal digit per clock,
//   LSD first, through a single corrected digit adder. Successor to the single-digit combinational

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_digit_add.sv | 21 ++
 rtl/bcd_serial_addsub.sv | 137 +++++++++++++
 tb/tb_bcd_serial_addsub.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit helpers for the serial BCD adder/subtractor.
package bcd_pkg;

   localparam int unsigned BCD_W   = 4;
   localparam logic [3:0]  BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // 9's complement of one decimal digit; only meaningful for digits 0..9
   function automatic logic [3:0] nines_comp(input logic [3:0] digit);
      return BCD_MAX - digit;
   endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single corrected decimal digit adder: binary add, then +6 when the binary sum exceeds 9.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [4:0] bin;

   // Binary sum with decimal correction; the +6 skips the six unused codes 10..15
   always_comb begin
      bin  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      cout = (bin > {1'b0, BCD_MAX});
      s    = cout ? (bin[3:0] + 4'd6) : bin[3:0];
   end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one digit per clock, LSD first, through one
// corrected digit adder. Subtraction is A + 9's-complement(B) + 1 (10's complement).
module bcd_serial_addsub
   import bcd_pkg::*;
#(
   parameter int unsigned NDIGITS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NDIGITS-1:0] in_a,
   input  logic [4*NDIGITS-1:0] in_b,
   input  logic                 in_sub,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NDIGITS-1:0] out_sum,
   output logic                 out_cout,
   output logic                 out_err
);

   localparam int unsigned W    = BCD_W * NDIGITS;
   localparam int unsigned IW   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam logic [IW-1:0] LAST = IW'(NDIGITS - 1);

   state_e         state_q, state_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [W-1:0]   sum_q, sum_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic           carry_q, carry_d;
   logic           cout_q, cout_d;
   logic           err_q, err_d;

   logic [3:0]     dig_s;
   logic           dig_c;

   function automatic logic any_bad(input logic [W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < int'(NDIGITS); i++) begin
         if (v[i*BCD_W +: BCD_W] > BCD_MAX) bad = 1'b1;
      end
      return bad;
   endfunction

   function automatic logic [W-1:0] nines_all(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < int'(NDIGITS); i++) begin
         r[i*BCD_W +: BCD_W] = nines_comp(v[i*BCD_W +: BCD_W]);
      end
      return r;
   endfunction

   // Operand registers shift right so the current digit is always in the low nibble
   bcd_digit_add u_digit_add (
      .a    (a_q[BCD_W-1:0]),
      .b    (b_q[BCD_W-1:0]),
      .cin  (carry_q),
      .s    (dig_s),
      .cout (dig_c)
   );

   // Next-state logic for the handshake FSM and the digit datapath
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_sub ? nines_all(in_b) : in_b;
               carry_d = in_sub;
               err_d   = any_bad(in_a) | any_bad(in_b);
               idx_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = a_q >> BCD_W;
            b_d     = b_q >> BCD_W;
            carry_d = dig_c;
            idx_d   = idx_q + 1'b1;
            // New digit enters at the top; after NDIGITS shifts digit 0 sits at [3:0]
            sum_d   = err_q ? '0 : ((sum_q >> BCD_W) | (W'(dig_s) << (W - BCD_W)));
            if (idx_q == LAST) begin
               idx_d   = '0;
               cout_d  = err_q ? 1'b0 : dig_c;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         err_q   <= err_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;
   assign out_err   = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Scoreboard bench: driver pushes model results, a negedge monitor compares DUT outputs.
module tb_bcd_serial_addsub;

   localparam int N   = 4;
   localparam int W   = 4 * N;
   localparam int MOD = 10000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic          in_sub = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_sum;
   logic          out_cout;
   logic          out_err;

   logic          d1_in_valid = 1'b0;
   logic          d1_in_ready;
   logic [3:0]    d1_in_a = '0;
   logic [3:0]    d1_in_b = '0;
   logic          d1_in_sub = 1'b0;
   logic          d1_out_valid;
   logic          d1_out_ready = 1'b0;
   logic [3:0]    d1_out_sum;
   logic          d1_out_cout;
   logic          d1_out_err;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         err;
      int           acc;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   bit   stall = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   bcd_serial_addsub #(.NDIGITS(N)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_err   (out_err)
   );

   bcd_serial_addsub #(.NDIGITS(1)) u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (d1_in_valid),
      .in_ready  (d1_in_ready),
      .in_a      (d1_in_a),
      .in_b      (d1_in_b),
      .in_sub    (d1_in_sub),
      .out_valid (d1_out_valid),
      .out_ready (d1_out_ready),
      .out_sum   (d1_out_sum),
      .out_cout  (d1_out_cout),
      .out_err   (d1_out_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int bcd2int(input logic [W-1:0] v);
      int r;
      r = 0;
      for (int i = N - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
      return r;
   endfunction

   function automatic logic [W-1:0] int2bcd(input int v);
      logic [W-1:0] r;
      int           x;
      x = v;
      r = '0;
      for (int i = 0; i < N; i++) begin
         r[i*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Reference: decimal arithmetic on whole numbers, modulo 10^N
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      exp_t e;
      int   ia, ib, r;
      e.err = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9) e.err = 1'b1;
      end
      e.acc = 0;
      if (e.err) begin
         e.sum  = '0;
         e.cout = 1'b0;
      end else begin
         ia = bcd2int(a);
         ib = bcd2int(b);
         if (!sub) begin
            r      = ia + ib;
            e.cout = (r >= MOD);
            e.sum  = int2bcd(r % MOD);
         end else if (ia >= ib) begin
            e.cout = 1'b1;
            e.sum  = int2bcd(ia - ib);
         end else begin
            e.cout = 1'b0;
            e.sum  = int2bcd(MOD + ia - ib);
         end
      end
      return e;
   endfunction

   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                     input bit noise, input bit push);
      int   t;
      exp_t e;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", 32'(in_ready), 32'd1);
         return;
      end
      in_a     = a;
      in_b     = b;
      in_sub   = sub;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      if (push) begin
         e     = model(a, b, sub);
         e.acc = cyc;
         q.push_back(e);
      end
      if (noise) begin
         // Garbage operands while running must not disturb the result
         in_a   = 16'($urandom);
         in_b   = 16'($urandom);
         in_sub = ~sub;
         repeat (3) begin
            check("in_ready_run", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (q.size() != 0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("drain", 32'(q.size()), 32'd0);
   endtask

   function automatic logic [W-1:0] rnd_bcd();
      logic [W-1:0] v;
      int           p;
      v = int2bcd(int'($urandom_range(0, MOD - 1)));
      if ($urandom_range(0, 7) == 0) begin
         p = int'($urandom_range(0, N - 1));
         v[p*4 +: 4] = 4'($urandom_range(10, 15));
      end
      return v;
   endfunction

   // Consumer back-pressure, changed just after each rising edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready = stall ? 1'b0 : ($urandom_range(0, 2) != 0);
      end
   end

   // Monitor: every DONE cycle must show the head expectation; pop on handshake
   initial begin
      exp_t e;
      bit   prev_valid;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && out_valid) begin
            check("in_ready_in_done", 32'(in_ready), 32'd0);
            if (q.size() == 0) begin
               check("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
               e = q[0];
               // Consumer first samples out_valid at edge acc+N+1 after the accept edge
               if (!prev_valid) check("latency", 32'(cyc - e.acc + 1), 32'(N + 1));
               check("out_sum", 32'(out_sum), 32'(e.sum));
               check("out_cout", 32'(out_cout), 32'(e.cout));
               check("out_err", 32'(out_err), 32'(e.err));
               if (out_ready) void'(q.pop_front());
            end
         end
         prev_valid = !rst && out_valid;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] da[8];
      logic [W-1:0] db[8];
      logic         ds[8];
      int           t;
      int           acc;

      da = '{16'h1234, 16'h5000, 16'h1234, 16'h0000, 16'h9999, 16'h0000, 16'h12A4, 16'h0042};
      db = '{16'h8766, 16'h1234, 16'h5000, 16'h0000, 16'h0001, 16'h0000, 16'h0001, 16'h0017};
      ds = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_sum", 32'(out_sum), 32'd0);
      check("rst_out_cout", 32'(out_cout), 32'd0);
      check("rst_out_err", 32'(out_err), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) op(da[i], db[i], ds[i], (i % 2) == 1, 1'b1);
      drain();

      for (int i = 0; i < 60; i++) begin
         op(rnd_bcd(), rnd_bcd(), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'b1);
      end
      drain();

      // Held result: consumer stalls for several DONE cycles
      stall = 1'b1;
      op(16'h4321, 16'h0789, 1'b0, 1'b0, 1'b1);
      t = 0;
      while (!out_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("stall_reach_done", 32'(out_valid), 32'd1);
      repeat (3) @(negedge clk);
      stall = 1'b0;
      drain();

      // Reset while RUN is on digit 2: aborted, no result ever appears
      op(16'h1234, 16'h8766, 1'b0, 1'b0, 1'b0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_out_sum", 32'(out_sum), 32'd0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      op(16'h0500, 16'h0250, 1'b1, 1'b0, 1'b1);
      drain();

      // Single-digit instance: 7+5 and 3-5
      @(negedge clk);
      d1_in_a     = 4'd7;
      d1_in_b     = 4'd5;
      d1_in_sub   = 1'b0;
      d1_in_valid = 1'b1;
      @(posedge clk);
      #1;
      acc         = cyc;
      d1_in_valid = 1'b0;
      t = 0;
      while (!d1_out_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("n1_latency", 32'(cyc - acc + 1), 32'd2);
      check("n1_add_sum", 32'(d1_out_sum), 32'd2);
      check("n1_add_cout", 32'(d1_out_cout), 32'd1);
      check("n1_add_err", 32'(d1_out_err), 32'd0);
      d1_out_ready = 1'b1;
      @(posedge clk);
      #1;
      d1_out_ready = 1'b0;
      check("n1_back_idle", 32'(d1_in_ready), 32'd1);
      check("n1_valid_drop", 32'(d1_out_valid), 32'd0);

      d1_in_a     = 4'd3;
      d1_in_b     = 4'd5;
      d1_in_sub   = 1'b1;
      d1_in_valid = 1'b1;
      @(posedge clk);
      #1;
      d1_in_valid = 1'b0;
      t = 0;
      while (!d1_out_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("n1_sub_sum", 32'(d1_out_sum), 32'd8);
      check("n1_sub_cout", 32'(d1_out_cout), 32'd0);
      d1_out_ready = 1'b1;
      @(posedge clk);
      #1;
      d1_out_ready = 1'b0;

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
